// File: rtl/nibble_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl_pkg
// Description : Shared definitions for the nibble-serial add/subtract
//               sequencer. These are the controller state encoding and the
//               slice (nibble) width.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_add_ctrl_pkg;

    // Width of the time-shared adder slice.
    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/add_slice_4b.sv
`default_nettype none
// ============================================================================
// Module      : add_slice_4b
// Description : Combinational 4-bit ripple-carry adder slice built from four
//               full adders.
//   a, b   [3:0] in  : addends
//   cin          in  : carry into bit 0
//   sum    [3:0] out : a + b + cin (low 4 bits)
//   cout         out : carry out of bit 3
//   c_msb        out : carry into bit 3 (used for signed overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module add_slice_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c_msb
);

    // w_carry[i] is the carry into bit i; w_carry[4] is the slice carry out.
    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = w_carry[4];
    assign c_msb = w_carry[3];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : WIDTH-bit add/subtract sequencer. It time-shares one 4-bit
//               ripple-carry slice, processing one nibble per clock with the
//               LSB nibble first. The inter-nibble carry is held in a register.
//   clk          in  : rising-edge clock
//   rst_n        in  : asynchronous active-low reset
//   start        in  : request, accepted only while ready=1
//   sub          in  : 0 = a+b+cin, 1 = a-b (a+~b+1, cin ignored)
//   a, b [W-1:0] in  : operands, sampled on accept
//   cin          in  : add carry-in, sampled on accept
//   ready        out : high in IDLE
//   busy         out : high in RUN
//   done         out : one-cycle pulse when results update
//   sum  [W-1:0] out : registered result
//   cout         out : carry out of MSB (for sub, 1 = no borrow)
//   overflow     out : signed overflow of the full-width operation
// WIDTH must be a multiple of 4 and at least 8.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB  = WIDTH / NIBW;
    localparam int IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIB - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;      // shifted right one nibble per step
    logic [WIDTH-1:0]       r_b;      // already inverted for subtract
    logic                   r_carry;
    logic [IDXW-1:0]        r_idx;
    // Holds the lower NIB-1 result nibbles. The last nibble goes straight
    // from the slice into sum.
    logic [WIDTH-NIBW-1:0]  r_work;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_ready;

    logic [NIBW-1:0]        w_s_sum;
    logic                   w_s_cout;
    logic                   w_s_cmsb;

    add_slice_4b u_slice (
        .a     (r_a[NIBW-1:0]),
        .b     (r_b[NIBW-1:0]),
        .cin   (r_carry),
        .sum   (w_s_sum),
        .cout  (w_s_cout),
        .c_msb (w_s_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> NIBW;
                    r_b     <= r_b >> NIBW;
                    r_carry <= w_s_cout;
                    if (r_idx == c_last_idx) begin
                        // Final nibble: publish the complete result at once.
                        r_sum   <= {w_s_sum, r_work};
                        r_cout  <= w_s_cout;
                        r_ovf   <= w_s_cmsb ^ w_s_cout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_work[r_idx*NIBW +: NIBW] <= w_s_sum;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
//               Expected results are queued when an operation is issued and
//               are compared when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ready, busy, done, cout, overflow;
    logic [15:0] sum;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference arithmetic on 17 bits for random operands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        logic [15:0] yy;
        logic [16:0] full;
        exp_t        e;
        yy    = s ? ~y : y;
        full  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (x[15] == yy[15]) && (full[15] != x[15]);
        return e;
    endfunction

    // Issue one request. It returns at the negedge after the accept edge.
    task automatic drive_op(input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic s, input exp_t e);
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done. The edge count includes the accept edge.
    task automatic wait_done(input int edges_in, output int edges,
                             output int busy_cnt, output bit to);
        edges = edges_in; busy_cnt = 0; to = 1'b0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) busy_cnt++;
            if (edges >= 20) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if (sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0 ||
            done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b, want 0000 0 0 0 0 1",
                     sum, cout, overflow, done, busy, ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
        end
    endtask

    task automatic test_directed;
        vec_t v[8];
        exp_t e;
        int   edges, bcnt;
        bit   to;
        v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
        v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        v[2] = '{16'h000F, 16'h0000, 1'b1, 1'b0, '{16'h0010, 1'b0, 1'b0}};
        v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        v[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        v[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        v[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        v[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000F, 1'b1, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive_op(v[i].a, v[i].b, v[i].c, v[i].s, v[i].e);
            wait_done(1, edges, bcnt, to);
            e = sb.pop_front();
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL directed[%0d] timeout: no done within %0d edges", i, edges);
                continue;
            end
            if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
                miscompares++;
                $display("FAIL directed[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, sum, cout, overflow, e.sum, e.cout, e.ovf);
            end
            vectors++;
            if (edges !== 5 || bcnt !== 4) begin
                miscompares++;
                $display("FAIL directed[%0d] latency: got edges=%0d busy_cycles=%0d, want 5 4", i, edges, bcnt);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || ready !== 1'b1 || sum !== e.sum) begin
                miscompares++;
                $display("FAIL directed[%0d] post_done: got done=%b ready=%b sum=%h, want 0 1 %h",
                         i, done, ready, sum, e.sum);
            end
        end
    endtask

    task automatic test_ignore_start;
        exp_t e;
        int   edges, bcnt;
        bit   to;
        drive_op(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
        // A request during RUN must not disturb the latched operands.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hF0F0; b = 16'h0F0F;
        wait_done(3, edges, bcnt, to);
        e = sb.pop_front();
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL ignore_run timeout: no done within %0d edges", edges);
        end else if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL ignore_run: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        // A request in the DONE cycle must also be dropped.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_done: got busy=%b ready=%b, want 0 1", busy, ready);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (sum !== 16'h3333 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_done_hold: got sum=%h busy=%b, want 3333 0", sum, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int saw_done = 0;
        drive_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, '{16'h1010, 1'b0, 1'b0});
        void'(sb.pop_back());                 // this operation is aborted
        repeat (2) @(negedge clk);            // now in RUN with idx=2
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0 ||
            done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_run: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b, want 0000 0 0 0 0 1",
                     sum, cout, overflow, done, busy, ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || sum !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_release: got ready=%b busy=%b sum=%h, want 1 0 0000", ready, busy, sum);
        end
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) saw_done++;
            @(negedge clk);
        end
        vectors++;
        if (saw_done !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", saw_done);
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        logic [15:0] x, y;
        logic        c, s;
        int          edges, bcnt;
        bit          to;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                x = 16'h3C3C; y = 16'h0C4D; c = 1'b1; s = 1'b0;
            end else begin
                x = 16'($urandom); y = 16'($urandom);
                c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            end
            drive_op(x, y, c, s, model(x, y, c, s));
            wait_done(1, edges, bcnt, to);
            e = sb.pop_front();
            vectors++;
            if (to) begin
                miscompares++;
                $display("FAIL b2b[%0d] timeout: no done within %0d edges", i, edges);
            end else if (sum !== e.sum || cout !== e.cout || overflow !== e.ovf || edges !== 5) begin
                miscompares++;
                $display("FAIL b2b[%0d] a=%h b=%h cin=%b sub=%b: got sum=%h cout=%b ovf=%b edges=%0d, want sum=%h cout=%b ovf=%b edges=5",
                         i, x, y, c, s, sum, cout, overflow, edges, e.sum, e.cout, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
